// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-master bus between the instruction-fetch port and the
// data-access port of a CPU pipeline. Data accesses have fixed priority over
// fetches. One bus transaction is in flight at a time. The address, write
// data, write enable and byte lanes are captured when a request is accepted,
// so the bus side stays stable for the whole transaction. Each completion is
// reported with a one-cycle registered ready pulse on the requesting port.
//
// Optional feature (compile-time macro ARB_TIMEOUT_EN):
//   When defined, an 8-bit busy-cycle counter aborts a transaction that has
//   not seen bus_ack after TIMEOUT_CYCLES busy cycles. The abort pulses the
//   active ready output with read data 0 and pulses bus_err in the same
//   cycle. An ack arriving on the timeout cycle wins and completes normally.
//   When undefined, no counter exists, bus_err is tied to 0 and a transaction
//   waits for bus_ack indefinitely.
//
// Parameters
//   TIMEOUT_CYCLES  busy cycles allowed before abort (ARB_TIMEOUT_EN only)
//
// Ports
//   clock           rising-edge clock
//   reset           synchronous, active-high reset
//   if_req          fetch read request, held until if_ready
//   if_addr         fetch address
//   if_rdata        fetch read data, valid with if_ready, held otherwise
//   if_ready        one-cycle fetch completion pulse
//   mem_req         data request, held until mem_ready
//   mem_we          data write enable (1 = write)
//   mem_addr        data address
//   mem_wdata       data write data
//   mem_sel         data byte lane enables
//   mem_rdata       data read data, valid with mem_ready, held otherwise
//   mem_ready       one-cycle data completion pulse
//   bus_cyc         bus transaction active
//   bus_we          bus write enable
//   bus_addr        bus address
//   bus_wdata       bus write data
//   bus_sel         bus byte lanes
//   bus_rdata       bus read data
//   bus_ack         bus completion
//   bus_err         one-cycle timeout-abort pulse
//   stall_from_if   fetch-side stall to pipeline control (combinational)
//   stall_from_mem  data-side stall to pipeline control (combinational)
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  // fetch port
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  // data port
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_sel,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  // bus
  output logic        bus_cyc,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_sel,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_err,
  // pipeline control
  output logic        stall_from_if,
  output logic        stall_from_mem
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IBUS = 2'd1,
    DBUS = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  // Captured transaction fields driving the bus
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_sel;

  // Completion outputs
  logic [31:0] r_if_rdata;
  logic [31:0] r_mem_rdata;
  logic        r_if_ready;
  logic        r_mem_ready;

  logic        w_if_pend;
  logic        w_mem_pend;
  logic        w_busy;
  logic        w_timeout;
  logic        w_load_if;
  logic        w_load_mem;
  logic        w_done_if;
  logic        w_done_mem;
  logic        w_abort;

  // A requester is still held high during its own ready cycle; masking with
  // the ready pulse keeps that finished request from being accepted again,
  // while the other port may be accepted in the same IDLE cycle.
  assign w_mem_pend     = mem_req & ~r_mem_ready;
  assign w_if_pend      = if_req  & ~r_if_ready;
  assign stall_from_mem = w_mem_pend;
  assign stall_from_if  = w_if_pend;

  assign w_busy    = (r_state != IDLE);
  assign bus_cyc   = w_busy;
  assign bus_we    = r_we;
  assign bus_addr  = r_addr;
  assign bus_wdata = r_wdata;
  assign bus_sel   = r_sel;

  assign if_rdata  = r_if_rdata;
  assign if_ready  = r_if_ready;
  assign mem_rdata = r_mem_rdata;
  assign mem_ready = r_mem_ready;

`ifdef ARB_TIMEOUT_EN
  // The counter holds the number of completed busy cycles without ack, so
  // the last allowed busy cycle is the one where it equals TIMEOUT_CYCLES-1.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] r_to_cnt;
  logic       r_bus_err;

  assign w_timeout = (r_to_cnt == TO_LAST);
  assign bus_err   = r_bus_err;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_to_cnt  <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_bus_err <= w_abort;
      if (w_load_if || w_load_mem) begin
        r_to_cnt <= '0;
      end else if (w_busy && !bus_ack) begin
        r_to_cnt <= r_to_cnt + 8'd1;
      end
    end
  end
`else
  logic w_unused_cfg;

  assign w_unused_cfg = ^TIMEOUT_CYCLES;
  assign w_timeout    = 1'b0;
  assign bus_err      = 1'b0;
`endif

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and transaction control
  always_comb begin
    w_state_nxt = r_state;
    w_load_if   = 1'b0;
    w_load_mem  = 1'b0;
    w_done_if   = 1'b0;
    w_done_mem  = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      IDLE: begin
        // bus_ack is deliberately not looked at here
        if (w_mem_pend) begin
          w_state_nxt = DBUS;
          w_load_mem  = 1'b1;
        end else if (w_if_pend) begin
          w_state_nxt = IBUS;
          w_load_if   = 1'b1;
        end
      end
      IBUS: begin
        if (bus_ack) begin
          w_done_if   = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_timeout) begin
          w_done_if   = 1'b1;
          w_abort     = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      DBUS: begin
        if (bus_ack) begin
          w_done_mem  = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_timeout) begin
          w_done_mem  = 1'b1;
          w_abort     = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Captured bus fields and registered completion outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_sel       <= '0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
      r_if_ready  <= 1'b0;
      r_mem_ready <= 1'b0;
    end else begin
      r_if_ready  <= w_done_if;
      r_mem_ready <= w_done_mem;

      if (w_load_mem) begin
        r_we    <= mem_we;
        r_addr  <= mem_addr;
        r_wdata <= mem_wdata;
        r_sel   <= mem_sel;
      end else if (w_load_if) begin
        // Fetches are always full-word reads
        r_we    <= 1'b0;
        r_addr  <= if_addr;
        r_sel   <= 4'b1111;
      end

      // An aborted transaction returns zero instead of whatever is on the bus
      if (w_done_if) begin
        r_if_rdata <= w_abort ? 32'd0 : bus_rdata;
      end
      if (w_done_mem) begin
        r_mem_rdata <= w_abort ? 32'd0 : bus_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clock;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_sel;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        bus_cyc;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_sel;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        bus_err;
  logic        stall_from_if;
  logic        stall_from_mem;

  int checks = 0;
  int errors = 0;

`ifdef ARB_TIMEOUT_EN
  localparam int ACK_LIMIT = 4;
`else
  localparam int ACK_LIMIT = 10;
`endif

  mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .if_req         (if_req),
    .if_addr        (if_addr),
    .if_rdata       (if_rdata),
    .if_ready       (if_ready),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_sel        (mem_sel),
    .mem_rdata      (mem_rdata),
    .mem_ready      (mem_ready),
    .bus_cyc        (bus_cyc),
    .bus_we         (bus_we),
    .bus_addr       (bus_addr),
    .bus_wdata      (bus_wdata),
    .bus_sel        (bus_sel),
    .bus_rdata      (bus_rdata),
    .bus_ack        (bus_ack),
    .bus_err        (bus_err),
    .stall_from_if  (stall_from_if),
    .stall_from_mem (stall_from_mem)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    if_req    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    bus_ack   = 1'b0;
  endtask

  task automatic idle_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    if_req    = 1'b1;
    mem_req   = 1'b1;
    mem_we    = 1'b1;
    if_addr   = $urandom;
    mem_addr  = $urandom;
    mem_wdata = $urandom;
    mem_sel   = 4'hA;
    bus_ack   = 1'b1;
    bus_rdata = $urandom;
    tick();
    tick();
    checks++; if ({bus_cyc, if_ready, mem_ready, bus_err} !== 4'b0) begin errors++; $display("FAIL reset_ctrl got %b exp 0000", {bus_cyc, if_ready, mem_ready, bus_err}); end
    checks++; if ({bus_we, bus_sel} !== 5'b0) begin errors++; $display("FAIL reset_we_sel got %b exp 00000", {bus_we, bus_sel}); end
    checks++; if ({bus_addr, bus_wdata} !== 64'd0) begin errors++; $display("FAIL reset_addr_wdata got %h %h exp 0 0", bus_addr, bus_wdata); end
    checks++; if ({if_rdata, mem_rdata} !== 64'd0) begin errors++; $display("FAIL reset_rdata got %h %h exp 0 0", if_rdata, mem_rdata); end
    checks++; if ({stall_from_if, stall_from_mem} !== 2'b11) begin errors++; $display("FAIL reset_stall_hi got %b exp 11", {stall_from_if, stall_from_mem}); end
    mem_req = 1'b0;
    #1;
    checks++; if ({stall_from_if, stall_from_mem} !== 2'b10) begin errors++; $display("FAIL reset_stall_mix got %b exp 10", {stall_from_if, stall_from_mem}); end
    idle_inputs();
    reset = 1'b0;
    tick();
    checks++; if (bus_cyc !== 1'b0) begin errors++; $display("FAIL reset_release_cyc got %b exp 0", bus_cyc); end
  endtask

  task automatic test_fetch_read();
    idle_reset();
    if_req    = 1'b1;
    if_addr   = 32'h0000_0100;
    bus_rdata = 32'h2402_0005;
    #1;
    checks++; if (stall_from_if !== 1'b1) begin errors++; $display("FAIL fetch_stall_c0 got %b exp 1", stall_from_if); end
    tick();  // c1
    checks++; if ({bus_cyc, bus_we, bus_sel} !== 6'b1_0_1111) begin errors++; $display("FAIL fetch_bus_ctrl got %b exp 101111", {bus_cyc, bus_we, bus_sel}); end
    checks++; if (bus_addr !== 32'h100) begin errors++; $display("FAIL fetch_bus_addr got %h exp 00000100", bus_addr); end
    tick();  // c2
    checks++; if ({bus_cyc, if_ready} !== 2'b10) begin errors++; $display("FAIL fetch_wait got %b exp 10", {bus_cyc, if_ready}); end
    bus_ack = 1'b1;
    tick();  // c3
    checks++; if ({if_ready, bus_cyc} !== 2'b10) begin errors++; $display("FAIL fetch_ready got %b exp 10", {if_ready, bus_cyc}); end
    checks++; if (if_rdata !== 32'h2402_0005) begin errors++; $display("FAIL fetch_rdata got %h exp 24020005", if_rdata); end
    checks++; if (stall_from_if !== 1'b0) begin errors++; $display("FAIL fetch_stall_rdy got %b exp 0", stall_from_if); end
    bus_ack   = 1'b0;
    bus_rdata = 32'h1111_2222;
    tick();  // c4
    if_req = 1'b0;
    checks++; if ({if_ready, bus_cyc} !== 2'b00) begin errors++; $display("FAIL fetch_after got %b exp 00", {if_ready, bus_cyc}); end
    checks++; if (if_rdata !== 32'h2402_0005) begin errors++; $display("FAIL fetch_hold got %h exp 24020005", if_rdata); end
  endtask

  task automatic test_simultaneous();
    idle_reset();
    if_req    = 1'b1;
    if_addr   = 32'h0000_0200;
    mem_req   = 1'b1;
    mem_we    = 1'b1;
    mem_addr  = 32'h0000_0080;
    mem_wdata = 32'hDEAD_BEEF;
    mem_sel   = 4'hF;
    tick();  // c1
    checks++; if ({bus_cyc, bus_we, bus_sel} !== 6'b1_1_1111) begin errors++; $display("FAIL simul_first_ctrl got %b exp 111111", {bus_cyc, bus_we, bus_sel}); end
    checks++; if ({bus_addr, bus_wdata} !== {32'h80, 32'hDEAD_BEEF}) begin errors++; $display("FAIL simul_first_data got %h %h exp 00000080 deadbeef", bus_addr, bus_wdata); end
    bus_ack = 1'b1;
    #1;
    checks++; if (stall_from_if !== 1'b1) begin errors++; $display("FAIL simul_stall_c1 got %b exp 1", stall_from_if); end
    tick();  // c2
    checks++; if ({mem_ready, if_ready, bus_cyc} !== 3'b100) begin errors++; $display("FAIL simul_mem_done got %b exp 100", {mem_ready, if_ready, bus_cyc}); end
    checks++; if ({stall_from_if, stall_from_mem} !== 2'b10) begin errors++; $display("FAIL simul_stall_c2 got %b exp 10", {stall_from_if, stall_from_mem}); end
    bus_ack = 1'b0;
    tick();  // c3
    mem_req = 1'b0;
    checks++; if ({bus_cyc, bus_we, mem_ready} !== 3'b100) begin errors++; $display("FAIL simul_second_ctrl got %b exp 100", {bus_cyc, bus_we, mem_ready}); end
    checks++; if ({bus_addr, bus_sel} !== {32'h200, 4'hF}) begin errors++; $display("FAIL simul_second_addr got %h %h exp 00000200 f", bus_addr, bus_sel); end
    bus_ack   = 1'b1;
    bus_rdata = 32'h0000_1234;
    #1;
    checks++; if (stall_from_if !== 1'b1) begin errors++; $display("FAIL simul_stall_c3 got %b exp 1", stall_from_if); end
    tick();  // c4
    checks++; if ({if_ready, if_rdata} !== {1'b1, 32'h1234}) begin errors++; $display("FAIL simul_if_done got %b %h exp 1 00001234", if_ready, if_rdata); end
    checks++; if (stall_from_if !== 1'b0) begin errors++; $display("FAIL simul_stall_c4 got %b exp 0", stall_from_if); end
    bus_ack = 1'b0;
    tick();
    if_req = 1'b0;
  endtask

  task automatic test_zero_wait();
    idle_reset();
    bus_ack   = 1'b1;
    mem_req   = 1'b1;
    mem_we    = 1'b0;
    mem_addr  = 32'hA000_0010;
    mem_sel   = 4'h3;
    if_req    = 1'b1;
    if_addr   = 32'hB000_0020;
    bus_rdata = 32'h0101_0101;
    tick();  // c1
    checks++; if ({bus_cyc, bus_addr} !== {1'b1, 32'hA000_0010}) begin errors++; $display("FAIL zw_data_bus got %b %h exp 1 a0000010", bus_cyc, bus_addr); end
    bus_rdata = 32'h0202_0202;
    tick();  // c2
    checks++; if ({mem_ready, mem_rdata} !== {1'b1, 32'h0202_0202}) begin errors++; $display("FAIL zw_data_ready got %b %h exp 1 02020202", mem_ready, mem_rdata); end
    checks++; if (bus_cyc !== 1'b0) begin errors++; $display("FAIL zw_idle_gap got %b exp 0", bus_cyc); end
    bus_rdata = 32'h0303_0303;
    tick();  // c3
    mem_req = 1'b0;
    checks++; if ({bus_cyc, bus_addr, bus_sel} !== {1'b1, 32'hB000_0020, 4'hF}) begin errors++; $display("FAIL zw_fetch_bus got %b %h %h exp 1 b0000020 f", bus_cyc, bus_addr, bus_sel); end
    checks++; if ({mem_ready, if_ready} !== 2'b00) begin errors++; $display("FAIL zw_idle_ack_ignored got %b exp 00", {mem_ready, if_ready}); end
    bus_rdata = 32'h0404_0404;
    tick();  // c4
    checks++; if ({if_ready, if_rdata, bus_cyc} !== {1'b1, 32'h0404_0404, 1'b0}) begin errors++; $display("FAIL zw_fetch_ready got %b %h %b exp 1 04040404 0", if_ready, if_rdata, bus_cyc); end
    tick();  // c5
    if_req = 1'b0;
    checks++; if ({bus_cyc, if_ready, mem_ready} !== 3'b000) begin errors++; $display("FAIL zw_quiet got %b exp 000", {bus_cyc, if_ready, mem_ready}); end
    bus_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    idle_reset();
    mem_req  = 1'b1;
    mem_we   = 1'b0;
    mem_addr = 32'h0000_0010;
    tick();  // c1
    bus_ack   = 1'b1;
    bus_rdata = 32'hCAFE_F00D;
    tick();  // c2
    bus_ack = 1'b0;
    checks++; if ({mem_ready, mem_rdata} !== {1'b1, 32'hCAFE_F00D}) begin errors++; $display("FAIL rmid_pre_read got %b %h exp 1 cafef00d", mem_ready, mem_rdata); end
    tick();  // c3
    mem_req = 1'b0;
    tick();  // c4
    mem_req   = 1'b1;
    mem_we    = 1'b1;
    mem_addr  = 32'h0000_0044;
    mem_wdata = 32'h0000_0011;
    tick();  // c5
    checks++; if ({bus_cyc, bus_addr} !== {1'b1, 32'h44}) begin errors++; $display("FAIL rmid_busy got %b %h exp 1 00000044", bus_cyc, bus_addr); end
    reset   = 1'b1;
    mem_req = 1'b0;
    tick();  // c6
    reset     = 1'b0;
    bus_ack   = 1'b1;
    bus_rdata = 32'h7777_7777;
    checks++; if ({bus_cyc, mem_ready} !== 2'b00) begin errors++; $display("FAIL rmid_abort got %b exp 00", {bus_cyc, mem_ready}); end
    checks++; if ({mem_rdata, bus_addr} !== 64'd0) begin errors++; $display("FAIL rmid_cleared got %h %h exp 0 0", mem_rdata, bus_addr); end
    tick();  // c7
    checks++; if ({bus_cyc, mem_ready, if_ready} !== 3'b000) begin errors++; $display("FAIL rmid_late_ack got %b exp 000", {bus_cyc, mem_ready, if_ready}); end
    tick();  // c8
    checks++; if ({bus_cyc, mem_ready, mem_rdata} !== {2'b00, 32'd0}) begin errors++; $display("FAIL rmid_idle got %b %b %h exp 0 0 0", bus_cyc, mem_ready, mem_rdata); end
    bus_ack = 1'b0;
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    idle_reset();
    mem_req  = 1'b1;
    mem_we   = 1'b0;
    mem_addr = 32'h0000_0020;
    tick();
    bus_ack   = 1'b1;
    bus_rdata = 32'h0000_A5A5;
    tick();
    bus_ack = 1'b0;
    checks++; if ({mem_ready, mem_rdata} !== {1'b1, 32'hA5A5}) begin errors++; $display("FAIL to_pre_read got %b %h exp 1 0000a5a5", mem_ready, mem_rdata); end
    tick();
    mem_req = 1'b0;
    tick();  // c4: new request, never acked
    mem_req   = 1'b1;
    mem_we    = 1'b1;
    mem_addr  = 32'h0000_0300;
    bus_rdata = 32'hFFFF_FFFF;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++; if ({bus_cyc, mem_ready, bus_err} !== 3'b100) begin errors++; $display("FAIL to_busy%0d got %b exp 100", k, {bus_cyc, mem_ready, bus_err}); end
    end
    tick();
    checks++; if ({bus_cyc, mem_ready, bus_err} !== 3'b011) begin errors++; $display("FAIL to_abort got %b exp 011", {bus_cyc, mem_ready, bus_err}); end
    checks++; if (mem_rdata !== 32'd0) begin errors++; $display("FAIL to_rdata got %h exp 0", mem_rdata); end
    tick();
    mem_req = 1'b0;
    checks++; if ({bus_err, mem_ready} !== 2'b00) begin errors++; $display("FAIL to_after got %b exp 00", {bus_err, mem_ready}); end
  endtask

  task automatic test_timeout_ack();
    idle_reset();
    mem_req  = 1'b1;
    mem_we   = 1'b0;
    mem_addr = 32'h0000_0400;
    for (int k = 1; k <= 3; k++) begin
      tick();
    end
    tick();  // 4th busy cycle: ack collides with timeout
    bus_ack   = 1'b1;
    bus_rdata = 32'h0000_5A5A;
    tick();
    bus_ack = 1'b0;
    checks++; if ({mem_ready, bus_err, bus_cyc} !== 3'b100) begin errors++; $display("FAIL to_ack_done got %b exp 100", {mem_ready, bus_err, bus_cyc}); end
    checks++; if (mem_rdata !== 32'h5A5A) begin errors++; $display("FAIL to_ack_rdata got %h exp 00005a5a", mem_rdata); end
    tick();
    mem_req = 1'b0;
  endtask
`endif

  task automatic test_random();
    bit          p_busy, p_ack, p_pend_m, p_pend_i;
    bit          e_busy, exp_mr, exp_ir, own_d, m_drop, i_drop;
    int          busy_len;
    logic [31:0] p_rdata, exp_mrd, exp_ird, t_addr, t_wdata;
    logic        t_we;
    logic [3:0]  t_sel;
    idle_reset();
    p_busy = 0; p_ack = 0; p_pend_m = 0; p_pend_i = 0;
    m_drop = 0; i_drop = 0; own_d = 0; busy_len = 0;
    p_rdata = '0; exp_mrd = '0; exp_ird = '0;
    t_addr = '0; t_wdata = '0; t_we = 0; t_sel = '0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      tick();
      // reference: bus goes busy one cycle after a pending request seen
      // while idle, and idle one cycle after an ack
      e_busy = p_busy ? !p_ack : (p_pend_m | p_pend_i);
      exp_mr = p_busy && p_ack && own_d;
      exp_ir = p_busy && p_ack && !own_d;
      if (exp_mr) exp_mrd = p_rdata;
      if (exp_ir) exp_ird = p_rdata;
      if (!p_busy && e_busy) begin
        own_d    = p_pend_m;
        t_we     = own_d ? mem_we : 1'b0;
        t_addr   = own_d ? mem_addr : if_addr;
        t_sel    = own_d ? mem_sel : 4'hF;
        t_wdata  = mem_wdata;
        busy_len = 0;
      end
      checks++; if (bus_cyc !== e_busy) begin errors++; $display("FAIL rnd_cyc c%0d got %b exp %b", cyc, bus_cyc, e_busy); end
      if (e_busy) begin
        checks++; if ({bus_we, bus_addr, bus_sel} !== {t_we, t_addr, t_sel}) begin errors++; $display("FAIL rnd_bus c%0d got %b %h %h exp %b %h %h", cyc, bus_we, bus_addr, bus_sel, t_we, t_addr, t_sel); end
        if (own_d) begin
          checks++; if (bus_wdata !== t_wdata) begin errors++; $display("FAIL rnd_wdata c%0d got %h exp %h", cyc, bus_wdata, t_wdata); end
        end
      end
      checks++; if ({mem_ready, if_ready, bus_err} !== {exp_mr, exp_ir, 1'b0}) begin errors++; $display("FAIL rnd_ready c%0d got %b exp %b", cyc, {mem_ready, if_ready, bus_err}, {exp_mr, exp_ir, 1'b0}); end
      checks++; if ({mem_rdata, if_rdata} !== {exp_mrd, exp_ird}) begin errors++; $display("FAIL rnd_rdata c%0d got %h %h exp %h %h", cyc, mem_rdata, if_rdata, exp_mrd, exp_ird); end

      // data master
      if (m_drop) begin
        m_drop = 0;
        mem_req = 1'b0;
      end
      if (!mem_req && !exp_mr && $urandom_range(0, 2) == 0) begin
        mem_req   = 1'b1;
        mem_we    = 1'($urandom);
        mem_addr  = $urandom;
        mem_wdata = $urandom;
        mem_sel   = 4'($urandom);
      end
      if (exp_mr) m_drop = 1;
      // fetch master
      if (i_drop) begin
        i_drop = 0;
        if_req = 1'b0;
      end
      if (!if_req && !exp_ir && $urandom_range(0, 2) == 0) begin
        if_req  = 1'b1;
        if_addr = $urandom;
      end
      if (exp_ir) i_drop = 1;
      // bus slave
      bus_rdata = $urandom;
      if (e_busy) begin
        busy_len++;
        bus_ack = (busy_len >= ACK_LIMIT) || ($urandom_range(0, 2) == 0);
      end else begin
        bus_ack = ($urandom_range(0, 3) == 0);
      end
      #1;
      checks++; if ({stall_from_mem, stall_from_if} !== {mem_req & ~exp_mr, if_req & ~exp_ir}) begin errors++; $display("FAIL rnd_stall c%0d got %b%b exp %b%b", cyc, stall_from_mem, stall_from_if, mem_req & ~exp_mr, if_req & ~exp_ir); end

      p_busy   = e_busy;
      p_ack    = bus_ack;
      p_pend_m = mem_req & ~exp_mr;
      p_pend_i = if_req & ~exp_ir;
      p_rdata  = bus_rdata;
    end
    idle_inputs();
  endtask

  initial begin
    reset     = 1'b1;
    if_req    = 1'b0;
    if_addr   = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_sel   = '0;
    bus_rdata = '0;
    bus_ack   = 1'b0;
    test_reset();
    test_fetch_read();
    test_simultaneous();
    test_zero_wait();
    test_reset_mid();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
    test_timeout_ack();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255, meaning bus cycles allowed before abort (used only when ARB_TIMEOUT_EN is defined).
REQ-002 The ports SHALL be as follows.
- clock  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- if_req  in  1  fetch read request, held until if_ready
- if_addr  in  32  fetch address
- if_rdata  out  32  fetch read data, valid with if_ready
- if_ready  out  1  one-cycle fetch completion pulse
- mem_req  in  1  data access request, held until mem_ready
- mem_we  in  1  1 = write, 0 = read
- mem_addr  in  32  data address
- mem_wdata  in  32  write data
- mem_sel  in  4  byte lane enables
- mem_rdata  out  32  data read data, valid with mem_ready
- mem_ready  out  1  one-cycle data completion pulse
- bus_cyc  out  1  bus transaction active
- bus_we  out  1  bus write enable
- bus_addr  out  32  bus address
- bus_wdata  out  32  bus write data
- bus_sel  out  4  bus byte lanes
- bus_rdata  in  32  bus read data
- bus_ack  in  1  bus completion
- bus_err  out  1  one-cycle timeout-abort pulse
- stall_from_if  out  1  stall request to pipeline control, fetch side
- stall_from_mem  out  1  stall request to pipeline control, data side

Function
REQ-003 The FSM SHALL have the states IDLE, IBUS (fetch in flight) and DBUS (data access in flight).
REQ-004 In IDLE with mem_req=1, the block SHALL latch mem_we, mem_addr, mem_wdata and mem_sel and enter DBUS next cycle.
REQ-005 In IDLE with mem_req=0 and if_req=1, the block SHALL latch if_addr, set we=0 and sel=4'b1111, and enter IBUS next cycle.
REQ-006 When both requests are present in IDLE, data SHALL win (fixed priority) and fetch SHALL wait.
REQ-007 bus_cyc SHALL be 1 exactly while in IBUS or DBUS; bus_we, bus_addr, bus_wdata and bus_sel SHALL be driven from latched registers and stay stable for the whole transaction.
REQ-008 On bus_ack=1 in DBUS, the block SHALL register bus_rdata into mem_rdata, pulse mem_ready for one cycle and return to IDLE; IBUS SHALL do the same with if_rdata and if_ready.
REQ-009 Minimum latency SHALL be 2 cycles: request sampled in IDLE at cycle N, bus_cyc high at N+1, ack at N+1, ready at N+2.
REQ-010 bus_ack SHALL be ignored in IDLE.
REQ-011 After a ready pulse the FSM SHALL be in IDLE for exactly one cycle before it accepts the next request (back-to-back requests are allowed).
REQ-012 stall_from_mem SHALL equal mem_req & ~mem_ready, combinationally.
REQ-013 stall_from_if SHALL equal if_req & ~if_ready, combinationally.
REQ-014 if_rdata and mem_rdata SHALL hold their last value between ready pulses.
REQ-015 Without ARB_TIMEOUT_EN, bus_err SHALL be constant 0.

Reset
REQ-016 With reset=1 at a clock edge, the FSM SHALL go to IDLE, and bus_cyc, if_ready, mem_ready and bus_err SHALL go to 0.
REQ-017 With reset=1 at a clock edge, the latched registers, if_rdata and mem_rdata SHALL go to 0.
REQ-018 Reset during IBUS or DBUS SHALL abort the transaction: bus_cyc is 0 from the next cycle, and any later bus_ack produces no ready pulse.
REQ-019 stall_from_if and stall_from_mem SHALL follow REQ-012 and REQ-013 even during reset.

Configuration
REQ-020 With ARB_TIMEOUT_EN defined, an 8-bit counter SHALL clear on entry to IBUS or DBUS and increment every busy cycle without bus_ack.
- When the count reaches TIMEOUT_CYCLES: drop bus_cyc, pulse the active ready output with read data 0, pulse bus_err in the same cycle, return to IDLE.
- bus_ack in the same cycle as timeout takes precedence: normal completion, no bus_err.
REQ-021 Without ARB_TIMEOUT_EN, no counter SHALL exist and a transaction SHALL wait for bus_ack indefinitely.

Verification
REQ-022 Fetch read: if_req=1, if_addr=0x00000100; bus_ack one cycle after bus_cyc with rdata=0x24020005 -> bus_addr=0x100, bus_sel=4'hF, if_ready pulse with if_rdata=0x24020005, 3 cycles after the request.
REQ-023 Simultaneous requests: if_req and mem_req in the same cycle, mem_addr=0x80, mem_we=1, mem_wdata=0xDEADBEEF -> the data write goes first, then the fetch; stall_from_if stays 1 until if_ready.
REQ-024 Zero-wait ack: bus_ack tied high -> ready 2 cycles after the request; one IDLE cycle between back-to-back accesses.
REQ-025 Reset mid-DBUS: reset=1 one cycle, then bus_ack=1 -> no mem_ready, bus_cyc=0, FSM in IDLE.
REQ-026 With ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, bus_ack never asserted -> after 4 busy cycles, bus_err and mem_ready pulse together with mem_rdata=0.
REQ-027 Ack arriving on the timeout cycle -> normal completion, bus_err=0.
